// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types, default widths and the arbitration rule for mem_arbiter.
// Latency: none (types and a pure function only).
// Backpressure: none.
//
// Contents:
//   DEF_*         default parameter values for mem_arbiter
//   arb_state_t   sequencer states
//   arb_gnt_t     which requester owns the memory port
//   pick_grant()  data-side priority with the instruction-side starvation override
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;
   localparam int DEF_TIMEOUT      = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } arb_gnt_t;

   // D wins a contested cycle unless I has already been passed over the
   // maximum number of times in a row. Caller guarantees at least one request.
   function automatic arb_gnt_t pick_grant(input logic want_i,
                                           input logic want_d,
                                           input logic starved);
      arb_gnt_t g;
      g = GNT_I;
      if (want_d && !(want_i && starved)) begin
         g = GNT_D;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: one memory port shared by ICache refill and DCache, D-side priority with I-side starvation guard and timeout.
// Latency: request seen in IDLE at N -> mem_req at N+1; mem_valid at M -> resp pulse at M+1, next mem_req no earlier than M+3.
// Backpressure: one transaction in flight; requesters hold req until their resp pulse, memory completion is bounded by TIMEOUT.
//
// Ports:
//   clock, reset                   single rising-edge clock, synchronous active-high reset
//   i_req, i_addr                  instruction read request (held until i_resp_valid)
//   i_resp_valid, i_rdata          instruction response pulse and read data
//   d_req, d_we, d_addr, d_wdata   data read/write request (held until d_resp_valid)
//   d_resp_valid, d_rdata          data response pulse and read data (0 for writes)
//   resp_err                       accompanies a resp_valid pulse when the access timed out
//   mem_req, mem_we, mem_addr,
//   mem_wdata                      memory issue pulse and command, held from ISSUE through DONE
//   mem_rdata, mem_valid           memory completion (reads and writes)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_resp_valid,
   output logic [DATA_W-1:0] i_rdata,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_rdata,

   output logic              resp_err,

   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   arb_state_t        state;
   arb_state_t        state_nxt;
   arb_gnt_t          gnt;
   arb_gnt_t          gnt_nxt;
   logic [SC_W-1:0]   starve_cnt;
   logic [SC_W-1:0]   starve_nxt;
   logic [TO_W-1:0]   to_cnt;
   logic [TO_W-1:0]   to_cnt_nxt;

   logic              mem_req_nxt;
   logic              mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;

   logic              i_resp_valid_nxt;
   logic              d_resp_valid_nxt;
   logic              resp_err_nxt;
   logic [DATA_W-1:0] i_rdata_nxt;
   logic [DATA_W-1:0] d_rdata_nxt;

   // Completion data for the granted side: memory data on a read,
   // zero on a write or on a timeout.
   logic [DATA_W-1:0] done_data;
   logic              finish;
   logic              starved;

   assign starved = (starve_cnt == STARVE_MAX);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt        = state;
      gnt_nxt          = gnt;
      starve_nxt       = starve_cnt;
      to_cnt_nxt       = to_cnt;

      mem_req_nxt      = 1'b0;
      mem_we_nxt       = mem_we;
      mem_addr_nxt     = mem_addr;
      mem_wdata_nxt    = mem_wdata;

      i_resp_valid_nxt = 1'b0;
      d_resp_valid_nxt = 1'b0;
      resp_err_nxt     = 1'b0;
      i_rdata_nxt      = i_rdata;
      d_rdata_nxt      = d_rdata;

      done_data        = '0;
      finish           = 1'b0;

      unique case (state)
         IDLE: begin
            if (i_req || d_req) begin
               gnt_nxt     = pick_grant(i_req, d_req, starved);
               mem_req_nxt = 1'b1;
               state_nxt   = ISSUE;

               if (gnt_nxt == GNT_D) begin
                  mem_we_nxt    = d_we;
                  mem_addr_nxt  = d_addr;
                  mem_wdata_nxt = d_wdata;
                  // Count only the D grants that actually made I wait.
                  if (i_req) begin
                     if (!starved) begin
                        starve_nxt = starve_cnt + SC_W'(1);
                     end
                  end else begin
                     starve_nxt = '0;
                  end
               end else begin
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = i_addr;
                  mem_wdata_nxt = '0;
                  starve_nxt    = '0;
               end
            end
         end

         ISSUE: begin
            to_cnt_nxt = '0;
            state_nxt  = WAIT;
         end

         WAIT: begin
            // A completion in the last counted cycle still wins over the timeout.
            if (mem_valid) begin
               finish    = 1'b1;
               done_data = mem_we ? '0 : mem_rdata;
            end else if (to_cnt == TO_LAST) begin
               finish       = 1'b1;
               resp_err_nxt = 1'b1;
            end else begin
               to_cnt_nxt = to_cnt + TO_W'(1);
            end

            if (finish) begin
               state_nxt = DONE;
               if (gnt == GNT_D) begin
                  d_resp_valid_nxt = 1'b1;
                  d_rdata_nxt      = done_data;
               end else begin
                  i_resp_valid_nxt = 1'b1;
                  i_rdata_nxt      = done_data;
               end
            end
         end

         DONE: begin
            // No arbitration here: gives the served requester a cycle to
            // drop or change its request before IDLE samples it again.
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registered outputs and counters
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         gnt          <= GNT_I;
         starve_cnt   <= '0;
         to_cnt       <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         i_resp_valid <= 1'b0;
         d_resp_valid <= 1'b0;
         resp_err     <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
      end else begin
         gnt          <= gnt_nxt;
         starve_cnt   <= starve_nxt;
         to_cnt       <= to_cnt_nxt;
         mem_req      <= mem_req_nxt;
         mem_we       <= mem_we_nxt;
         mem_addr     <= mem_addr_nxt;
         mem_wdata    <= mem_wdata_nxt;
         i_resp_valid <= i_resp_valid_nxt;
         d_resp_valid <= d_resp_valid_nxt;
         resp_err     <= resp_err_nxt;
         i_rdata      <= i_rdata_nxt;
         d_rdata      <= d_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory against a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SL = 4;
   localparam int TO = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_resp_valid;
   logic [DW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_resp_valid;
   logic [DW-1:0] d_rdata;
   logic          resp_err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_valid = 1'b0;

   always #5 clock = ~clock;

   mem_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (SL),
      .TIMEOUT      (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_resp_valid (i_resp_valid),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_resp_valid (d_resp_valid),
      .d_rdata      (d_rdata),
      .resp_err     (resp_err),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_valid    (mem_valid)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle-time %0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   int            cyc = 0;
   bit            i_pend = 0, d_pend = 0;
   logic [AW-1:0] ia = '0, da = '0;
   logic          dwe = 1'b0;
   logic [DW-1:0] dwd = '0;

   bit            busy = 0;
   int            arb_ready = 0;
   int            issue_cyc = -1, resp_cyc = -1, mv_cyc = -1, rst_chk = -1;
   bit            mv_real = 0;
   bit            t_side_d = 0, t_err = 0;
   logic          t_we = 1'b0;
   logic [AW-1:0] t_addr = '0;
   logic [DW-1:0] t_wdata = '0, t_data = '0;
   logic [DW-1:0] exp_ir = '0, exp_dr = '0;
   int            starve = 0;
   int            last_mv = -100;

   // knobs
   int            p_i = 0, p_d = 0, lat_fix = 1;
   bit            use_fixed = 0;
   logic [DW-1:0] fixed_rdata = '0;
   bit            rst_req = 0;
   bit            b2b = 0, b2b_armed = 0;

   // One clock cycle: check DUT outputs, then drive this cycle's inputs,
   // then let the model arbitrate on what was just driven.
   task automatic step();
      logic [3:0] exp_p;
      bit         rst_this;
      int         lat;
      @(posedge clock);
      #1;
      cyc++;

      exp_p = {issue_cyc == cyc,
               resp_cyc == cyc && !t_side_d,
               resp_cyc == cyc && t_side_d,
               resp_cyc == cyc && t_err};
      check_val("pulses", 64'({mem_req, i_resp_valid, d_resp_valid, resp_err}), 64'(exp_p));

      if (b2b && mem_req) begin
         if (b2b_armed) check_val("b2b_gap", 64'(cyc - last_mv), 64'd3);
         b2b_armed = 1'b1;
      end

      if (rst_chk == cyc) begin
         check_val("rst_mem_we", 64'(mem_we), 64'd0);
         check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
         check_val("rst_mem_wdata", 64'(mem_wdata), 64'd0);
         check_val("rst_i_rdata", 64'(i_rdata), 64'd0);
         check_val("rst_d_rdata", 64'(d_rdata), 64'd0);
      end

      if (issue_cyc == cyc) begin
         check_val("issue_addr", 64'(mem_addr), 64'(t_addr));
         check_val("issue_we", 64'(mem_we), 64'(t_we));
         check_val("issue_wdata", 64'(mem_wdata), 64'(t_wdata));
      end

      if (resp_cyc == cyc) begin
         check_val("hold_addr", 64'(mem_addr), 64'(t_addr));
         check_val("hold_we", 64'(mem_we), 64'(t_we));
         if (t_side_d) begin
            exp_dr = t_data;
            d_pend = 0;
         end else begin
            exp_ir = t_data;
            i_pend = 0;
         end
         check_val("i_rdata", 64'(i_rdata), 64'(exp_ir));
         check_val("d_rdata", 64'(d_rdata), 64'(exp_dr));
         busy      = 0;
         arb_ready = cyc + 1;
      end

      // ---- drive ----
      rst_this = rst_req;
      rst_req  = 0;
      reset    = rst_this;
      if (rst_this) begin
         busy      = 0;
         issue_cyc = -1;
         resp_cyc  = -1;
         i_pend    = 0;
         d_pend    = 0;
         starve    = 0;
         exp_ir    = '0;
         exp_dr    = '0;
         arb_ready = cyc + 1;
         rst_chk   = cyc + 1;
         mv_cyc    = cyc + 1;   // completion arriving after reset must be dropped
         mv_real   = 0;
      end

      mem_valid = (mv_cyc == cyc);
      mem_rdata = use_fixed ? fixed_rdata : DW'($urandom);
      if (mem_valid && mv_real) t_data = t_we ? '0 : mem_rdata;
      if (mem_valid) last_mv = cyc;

      if (!rst_this) begin
         if (!i_pend && $urandom_range(99) < p_i) begin
            i_pend = 1;
            ia     = AW'($urandom);
         end
         if (!d_pend && $urandom_range(99) < p_d) begin
            d_pend = 1;
            dwe    = 1'($urandom_range(1));
            da     = AW'($urandom);
            dwd    = DW'($urandom);
         end
      end
      i_req   = i_pend;
      i_addr  = ia;
      d_req   = d_pend;
      d_we    = dwe;
      d_addr  = da;
      d_wdata = dwd;

      // ---- model arbitration on the requests driven this cycle ----
      if (!rst_this && !busy && cyc >= arb_ready && (i_pend || d_pend)) begin
         t_side_d = d_pend && !(i_pend && starve == SL);
         if (t_side_d) begin
            t_addr  = da;
            t_we    = dwe;
            t_wdata = dwd;
            if (i_pend) starve = (starve < SL) ? starve + 1 : starve;
            else        starve = 0;
         end else begin
            t_addr  = ia;
            t_we    = 1'b0;
            t_wdata = '0;
            starve  = 0;
         end
         busy      = 1;
         issue_cyc = cyc + 1;
         if (lat_fix >= 0) lat = lat_fix;
         else              lat = ($urandom_range(99) < 15) ? 0 : int'($urandom_range(1, TO));
         if (lat == 0) begin
            // no completion inside the window: error response TO+1 after mem_req,
            // plus a stray completion that must be ignored
            t_err    = 1;
            t_data   = '0;
            resp_cyc = issue_cyc + TO + 1;
            mv_cyc   = resp_cyc + int'($urandom_range(1));
            mv_real  = 0;
         end else begin
            t_err    = 0;
            mv_cyc   = issue_cyc + lat;
            resp_cyc = mv_cyc + 1;
            mv_real  = 1;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((busy || i_pend || d_pend) && n < budget) begin
         step();
         n++;
      end
      if (busy || i_pend || d_pend) check_val("drain_budget", 64'd1, 64'd0);
      repeat (3) step();
   endtask

   initial begin
      int nd;
      bit got_i;
      int n;

      // reset
      rst_req = 1;
      step();
      step();

      // single I read
      use_fixed   = 1;
      fixed_rdata = 32'hDEADBEEF;
      lat_fix     = 2;
      i_pend      = 1;
      ia          = 32'h100;
      drain(50);

      // simultaneous I and D (D write wins)
      use_fixed = 0;
      lat_fix   = -1;
      i_pend    = 1;
      ia        = 32'h300;
      d_pend    = 1;
      dwe       = 1'b1;
      da        = 32'h400;
      dwd       = 32'h55;
      drain(100);

      // starvation: D always requesting, I held; two rounds
      lat_fix = 1;
      p_d     = 100;
      for (int r = 0; r < 2; r++) begin
         i_pend = 1;
         ia     = 32'h200 + 32'(r);
         nd     = 0;
         got_i  = 0;
         n      = 0;
         while (!got_i && n < 200) begin
            step();
            n++;
            if (i_resp_valid) got_i = 1;
            else if (d_resp_valid) nd++;
         end
         check_val("starve_d_grants", 64'(nd), 64'(SL));
      end
      p_d = 0;
      drain(100);

      // timeout with stray late completion
      lat_fix = 0;
      d_pend  = 1;
      dwe     = 1'b0;
      da      = 32'h500;
      drain(50);

      // back-to-back I reads
      lat_fix   = 1;
      b2b       = 1;
      b2b_armed = 0;
      p_i       = 100;
      repeat (30) step();
      p_i = 0;
      drain(50);
      b2b = 0;

      // random traffic
      lat_fix = -1;
      p_i     = 30;
      p_d     = 40;
      for (int k = 0; k < 1500 && errors < 20; k++) step();
      p_i = 0;
      p_d = 0;
      drain(200);

      // reset one cycle after mem_req, then a completion arrives
      lat_fix = 5;
      d_pend  = 1;
      dwe     = 1'b0;
      da      = 32'hABC0;
      for (int k = 0; k < 20 && cyc != issue_cyc; k++) step();
      check_val("rst_mid_issue_seen", 64'(mem_req), 64'd1);
      rst_req = 1;
      step();
      repeat (15) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer between the instruction cache refill path and the data-cache path. Both requesters share one memory port. The block accepts one request at a time, forwards it to memory, waits for completion or timeout, and routes the response back to the winner. Data-side priority applies, with a starvation guard for the instruction side. It sits between the ICache/DCache `mem_*` ports and the memory model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive D grants allowed while I is pending before I is forced
- `TIMEOUT`, 64, cycles in WAIT without `mem_valid` before an error completion
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `i_req` in 1: instruction-side request; held until `i_resp_valid`
- `i_addr` in ADDR_W: instruction read address; stable while `i_req`
- `i_resp_valid` out 1: one-cycle response pulse to instruction side
- `i_rdata` out DATA_W: read data, valid with `i_resp_valid`
- `d_req` in 1: data-side request; held until `d_resp_valid`
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: write data
- `d_resp_valid` out 1: one-cycle response pulse to data side
- `d_rdata` out DATA_W: read data; 0 for writes
- `resp_err` out 1: set with either `resp_valid` when the transaction timed out
- `mem_req` out 1: one-cycle issue pulse to memory
- `mem_we` out 1: write enable, valid with `mem_req`
- `mem_addr` out ADDR_W: registered address, held through WAIT
- `mem_wdata` out DATA_W: registered write data
- `mem_rdata` in DATA_W: memory read data
- `mem_valid` in 1: memory completion pulse, for reads and writes

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. The grant register `gnt` ∈ {I, D} is latched in IDLE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If `d_req` && `i_req`: grant D unless `starve_cnt` == `STARVE_LIMIT`, in which case grant I.
  - Otherwise grant whichever side is requesting.
  - On any grant, latch addr/we/wdata (I side: we = 0, wdata = 0) and go to ISSUE.
- **ISSUE**: assert `mem_req` for exactly one cycle, clear the timeout counter, then go to WAIT.
- **WAIT**
  - On `mem_valid`: capture `mem_rdata` (forced to 0 if we = 1), err = 0, go to DONE.
  - If the counter reaches `TIMEOUT - 1` with no `mem_valid`: data = 0, err = 1, go to DONE.
- **DONE**
  - Assert the granted side's `resp_valid` for one cycle, with data and `resp_err`, then return to IDLE.
  - No arbitration happens in DONE, so a requester sees its pulse and drops or changes `req` before the next IDLE.
- **starve_cnt** (width `$clog2(STARVE_LIMIT+1)`):
  - Increments on a D grant while `i_req` is high.
  - Clears on any I grant, or on a D grant while `i_req` is low.
  - Saturates at `STARVE_LIMIT`.
- `mem_valid` outside WAIT (late or spurious) is ignored and never produces a response.
- Reset mid-transaction abandons the transaction: no response is generated and a later `mem_valid` is ignored.

## Timing
- Reset values:
  - state = IDLE
  - all `*_resp_valid`, `resp_err`, `mem_req`, `mem_we` = 0
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0
  - `starve_cnt` = 0, timeout counter = 0
- All outputs are registered. There is no combinational path from any input to any output.
- A request seen in IDLE at cycle N gives `mem_req` at N+1. `mem_valid` at M gives `resp_valid` at M+1 and IDLE at M+2. The earliest next `mem_req` is M+3.
- Minimum turnaround, with `mem_valid` in the first WAIT cycle: request at N, response at N+3.
- Timeout: `resp_valid` with `resp_err` appears `TIMEOUT` + 1 cycles after `mem_req`.
- `mem_addr`, `mem_we` and `mem_wdata` hold their values from ISSUE through DONE.
- `i_rdata` and `d_rdata` hold their last value until overwritten.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t`
  - `typedef enum logic {GNT_I, GNT_D} arb_gnt_t`
  - default width constants
- Single module, no sub-modules. The starvation counter and timeout counter are inline.

## Test plan
- **Single I read**: `i_req`=1, `i_addr`=0x100, `mem_valid` with `mem_rdata`=0xDEADBEEF two cycles after `mem_req` -> `mem_addr`=0x100, `mem_we`=0; `i_rdata`=0xDEADBEEF with a one-cycle `i_resp_valid`; `d_resp_valid` stays 0.
- **Simultaneous requests**: `i_req` and `d_req` both high at the same cycle, `d_we`=1, `d_wdata`=0x55 -> D served first with `mem_we`=1 and `d_rdata`=0; I served next.
- **Starvation**: `i_req` held high while `d_req` is always high with `STARVE_LIMIT`=4 -> exactly 4 D grants, then an I grant, then `starve_cnt`=0.
- **Timeout**: `TIMEOUT`=8, memory never responds -> `d_resp_valid` and `resp_err`=1 exactly 9 cycles after `mem_req`; a later `mem_valid` is ignored.
- **Reset mid-WAIT**: assert `reset` one cycle after `mem_req`, then pulse `mem_valid` -> no `resp_valid` ever; all outputs at reset values.
- **Back-to-back I**: a new `i_addr` is presented the cycle after `i_resp_valid` -> its `mem_req` appears exactly 3 cycles after the previous `mem_valid`.
